// File: rtl/case5_sweep_misr.sv
// Exhaustive 64-pattern sequencer for the case5 netlist with a MISR response compactor.
// Each pattern is held SETTLE cycles; the final signature is compared against GOLDEN.
module case5_sweep_misr #(
   parameter int unsigned       SETTLE = 1,
   parameter int unsigned       MISR_W = 16,
   parameter logic [MISR_W-1:0] POLY   = 16'h8016,
   parameter logic [MISR_W-1:0] SEED   = 16'hFFFF,
   parameter logic [MISR_W-1:0] GOLDEN = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [5:0]        pat,
   input  logic [2:0]        resp,
   output logic              busy,
   output logic              done,
   output logic [MISR_W-1:0] signature,
   output logic              pass
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [3:0] W_LAST = 4'(SETTLE - 1);

   logic [1:0]        state_q, state_d;
   logic [5:0]        pat_q, pat_d;
   logic [3:0]        w_q, w_d;
   logic [MISR_W-1:0] sig_q, sig_d;
   logic              pass_q, pass_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [MISR_W-1:0] misr_fb;
   logic [MISR_W-1:0] misr_next;

   always_comb begin
      misr_fb   = sig_q[MISR_W-1] ? POLY : '0;
      misr_next = {sig_q[MISR_W-2:0], 1'b0} ^ misr_fb ^ {{(MISR_W-3){1'b0}}, resp};
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      w_d     = w_q;
      sig_d   = sig_q;
      pass_d  = pass_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               pat_d   = 6'd0;
               w_d     = 4'd0;
               sig_d   = SEED;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         StRun: begin
            busy_d = 1'b1;
            // Abort wins over a coincident sample edge; the partial signature is kept.
            if (abort) begin
               state_d = StIdle;
               pat_d   = 6'd0;
               w_d     = 4'd0;
               pass_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (w_q < W_LAST) begin
               w_d = w_q + 4'd1;
            end else begin
               sig_d = misr_next;
               pat_d = pat_q + 6'd1;
               w_d   = 4'd0;
               if (pat_q == 6'd63) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (misr_next == GOLDEN);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pat_q   <= 6'd0;
         w_q     <= 4'd0;
         sig_q   <= SEED;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         w_q     <= w_d;
         sig_q   <= sig_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pat       = pat_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign signature = sig_q;
   assign pass      = pass_q;

endmodule
